// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two registered read ports,
// optional hardwired-zero entry 0, optional write bypass and a sequential clear engine.
module regfile_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              busy
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
   logic [DATA_W-1:0] rd_data2_q, rd_data2_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              wr_ok;

   // Zero rule beats bypass; bypass only forwards writes that actually land.
   function automatic logic [DATA_W-1:0] read_value(
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] mem_val,
      input logic              fwd_en,
      input logic [ADDR_W-1:0] fwd_addr,
      input logic [DATA_W-1:0] fwd_data
   );
      logic [DATA_W-1:0] val;
      val = mem_val;
      if ((ZERO_REG != 0) && (addr == '0)) begin
         val = '0;
      end else if ((BYPASS != 0) && fwd_en && (fwd_addr == addr)) begin
         val = fwd_data;
      end
      return val;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= CLEAR;
         clr_cnt_q  <= '0;
         rd_data1_q <= '0;
         rd_data2_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         rd_data1_q <= rd_data1_d;
         rd_data2_q <= rd_data2_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            // Counter wraps to zero on the same edge that clears the last entry.
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == '1) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      wr_ok      = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
      mem_we     = 1'b0;
      mem_waddr  = wr_addr;
      mem_wdata  = wr_data;
      rd_data1_d = '0;
      rd_data2_d = '0;
      if (state_q == CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clr_cnt_q;
         mem_wdata = '0;
      end else begin
         mem_we     = wr_ok;
         rd_data1_d = read_value(rd_addr1, mem_q[rd_addr1], wr_ok, wr_addr, wr_data);
         rd_data2_d = read_value(rd_addr2, mem_q[rd_addr2], wr_ok, wr_addr, wr_data);
      end
   end

   assign rd_data1 = rd_data1_q;
   assign rd_data2 = rd_data2_q;
   assign busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default instance (zero reg + bypass) and an
// alternate instance (ordinary x0, no bypass) driven by the same stimulus.
module tb_regfile_param;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr_req;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [4:0]  rd_addr1;
   logic [4:0]  rd_addr2;
   logic [31:0] rd_data1, rd_data2;
   logic        busy;
   logic [31:0] alt_data1, alt_data2;
   logic        alt_busy;

   int compared = 0;
   int failed   = 0;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [31:0] exp1;
      logic [31:0] exp2;
      logic [31:0] alt1;
      logic [31:0] alt2;
   } vec_t;

   vec_t vecs [10];

   regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .clr_req(clr_req),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1), .rd_data2(rd_data2), .busy(busy)
   );

   regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_alt (
      .clk(clk), .rst(rst), .clr_req(clr_req),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(alt_data1), .rd_data2(alt_data2), .busy(alt_busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [4:0] ra1, input logic [4:0] ra2);
      wr_en    = we;
      wr_addr  = wa;
      wr_data  = wd;
      rd_addr1 = ra1;
      rd_addr2 = ra2;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Counts edges until both instances leave CLEAR; a clear must take 32.
   task automatic waitIdle(input string name);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while ((busy || alt_busy) && n < 100);
      checkOutput({name, " busy cycles"}, 32'(n), 32'd32);
      checkOutput({name, " alt busy"}, {31'd0, alt_busy}, 32'd0);
   endtask

   task automatic readAllZero(input string name);
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
         step();
         checkOutput({name, " rd1"}, rd_data1, 32'd0);
         checkOutput({name, " rd2"}, rd_data2, 32'd0);
         checkOutput({name, " alt rd1"}, alt_data1, 32'd0);
         checkOutput({name, " alt rd2"}, alt_data2, 32'd0);
      end
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
   endtask

   initial begin
      vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0};
      vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
      vecs[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
      vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};
      vecs[4] = '{1'b1, 5'd7,  32'h11,       5'd1,  5'd2,  32'h0,        32'h0,        32'h0,        32'h0};
      vecs[5] = '{1'b1, 5'd7,  32'h22,       5'd7,  5'd7,  32'h22,       32'h22,       32'h11,       32'h11};
      vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h22,       32'h22,       32'h22,       32'h22};
      vecs[7] = '{1'b0, 5'd7,  32'h99,       5'd7,  5'd7,  32'h22,       32'h22,       32'h22,       32'h22};
      vecs[8] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd7,  32'hA5A5A5A5, 32'h22,       32'h0,        32'h22};
      vecs[9] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};

      rst     = 1'b1;
      clr_req = 1'b0;
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

      // Reset release and initial clear
      repeat (3) step();
      checkOutput("reset rd1", rd_data1, 32'd0);
      checkOutput("reset rd2", rd_data2, 32'd0);
      checkOutput("reset busy", {31'd0, busy}, 32'd1);
      rst = 1'b0;
      waitIdle("post-reset");
      readAllZero("post-reset");

      // Write/read latency, zero register and bypass vectors
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
         step();
         checkOutput($sformatf("vec%0d rd1", i), rd_data1, vecs[i].exp1);
         checkOutput($sformatf("vec%0d rd2", i), rd_data2, vecs[i].exp2);
         checkOutput($sformatf("vec%0d alt rd1", i), alt_data1, vecs[i].alt1);
         checkOutput($sformatf("vec%0d alt rd2", i), alt_data2, vecs[i].alt2);
      end

      // Clear request with ignored second request and dropped write
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b1, 5'(i), 32'h1000_0000 | 32'(i), 5'd0, 5'd0);
         step();
      end
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
      step();
      checkOutput("fill x3", rd_data1, 32'h1000_0003);
      checkOutput("fill alt x0", alt_data2, 32'h1000_0000);
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      checkOutput("clr busy", {31'd0, busy}, 32'd1);
      begin
         int n;
         n = 0;
         do begin
            if (n == 4) applyStimulus(1'b1, 5'd3, 32'hAA, 5'd3, 5'd3);
            else        applyStimulus(1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
            clr_req = (n == 9);
            step();
            n++;
            if (n == 5) checkOutput("clr rd1 held zero", rd_data1, 32'd0);
         end while ((busy || alt_busy) && n < 100);
         clr_req = 1'b0;
         checkOutput("clr busy cycles", 32'(n), 32'd32);
      end
      readAllZero("post-clear");

      // Reset in the middle of a clear
      applyStimulus(1'b1, 5'd20, 32'h2020_2020, 5'd0, 5'd0);
      step();
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd20, 5'd20);
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      repeat (10) step();
      #3 rst = 1'b1;
      #1;
      checkOutput("midclr rst rd1", rd_data1, 32'd0);
      checkOutput("midclr rst busy", {31'd0, busy}, 32'd1);
      step();
      rst = 1'b0;
      waitIdle("midclr");
      readAllZero("midclr");

      // Asynchronous reset while idle with live read data
      applyStimulus(1'b1, 5'd9, 32'h0BADF00D, 5'd9, 5'd9);
      step();
      checkOutput("x9 bypass", rd_data1, 32'h0BADF00D);
      checkOutput("x9 alt old", alt_data1, 32'd0);
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
      step();
      checkOutput("x9 rd2", rd_data2, 32'h0BADF00D);
      checkOutput("x9 alt rd2", alt_data2, 32'h0BADF00D);
      #3 rst = 1'b1;
      #1;
      checkOutput("async rst rd1", rd_data1, 32'd0);
      checkOutput("async rst alt rd2", alt_data2, 32'd0);
      checkOutput("async rst busy", {31'd0, busy}, 32'd1);
      step();
      rst = 1'b0;
      waitIdle("idle-rst");
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
      step();
      checkOutput("x9 after rst", rd_data1, 32'd0);
      checkOutput("x9 alt after rst", alt_data1, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
